// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// 32-step shift-add multiply and restoring divide on operand magnitudes; sign fix-up in a final cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hilo_rd,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rs_raw_q, rs_raw_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        is_signed, rs_neg, rt_neg;
  logic [31:0] mag_rs, mag_rt;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic        div_ok;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    is_signed = ~op[0];
    rs_neg    = is_signed & rs_val[31];
    rt_neg    = is_signed & rt_val[31];
    mag_rs    = rs_neg ? -rs_val : rs_val;
    mag_rt    = rt_neg ? -rt_val : rt_val;

    // Multiply: multiplier shifts out of opa LSB-first, product enters acc from the top.
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (opa_q[0] ? opb_q : 32'd0)};

    // Divide: acc holds {remainder, quotient}; dividend bits shift out of opa MSB-first.
    div_shift = {acc_q[63:32], opa_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[32];

    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quot_fix  = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
    rem_fix   = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rs_raw_d  = rs_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (!op[2]) begin
            opa_d     = mag_rs;
            opb_d     = mag_rt;
            rs_raw_d  = rs_val;
            is_div_d  = op[1];
            neg_res_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            div0_d    = (rt_val == 32'd0);
            acc_d     = '0;
            count_d   = '0;
            state_d   = S_RUN;
          end else if (op == 3'b100) begin
            hi_d = rs_val;
          end else if (op == 3'b101) begin
            lo_d = rs_val;
          end
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = {(div_ok ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ok};
          opa_d = {opa_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
          opa_d = {1'b0, opa_q[31:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (div0_q) begin
          hi_d = rs_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rs_raw_q  <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rs_raw_q  <= rs_raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | hilo_rd);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of mul/div vectors plus hand sequences
// for MTHI/MTLO, flush, start-while-busy and asynchronous reset mid-operation.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        hilo_rd, flush;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hilo_rd(hilo_rd), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        hrd;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int unsigned busy_cnt;
    int unsigned stall_bad;
    int unsigned guard;
    busy_cnt  = 0;
    stall_bad = 0;
    guard     = 0;
    start = 1'b1; op = v.op; rs_val = v.rs; rt_val = v.rt;
    tick();
    start = 1'b0; hilo_rd = v.hrd;
    #1;
    while (busy && guard < 60) begin
      busy_cnt++;
      if (v.hrd && stall !== 1'b1) stall_bad++;
      if (done !== 1'b0) stall_bad++;
      tick();
      guard++;
    end
    chk({v.name, " busy_cycles"}, busy_cnt, 33);
    chk({v.name, " stall_done_during_busy"}, stall_bad, 0);
    chk({v.name, " done_pulse"}, {31'd0, done}, 1);
    chk({v.name, " hi"}, hi, v.exp_hi);
    chk({v.name, " lo"}, lo, v.exp_lo);
    if (v.hrd) chk({v.name, " stall_after"}, {31'd0, stall}, 0);
    hilo_rd = 1'b0;
    tick();
    chk({v.name, " done_cleared"}, {31'd0, done}, 0);
  endtask

  initial begin
    logic [31:0] old_hi, old_lo;

    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "MULT -3*7"};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, "MULTU max*max"};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "DIV -7/2"};
    vecs[3]  = '{3'b011, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b0, "DIVU 7/0"};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, "DIV min/-1"};
    vecs[5]  = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, "MULT maxpos^2"};
    vecs[6]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "DIVU 100/7"};
    vecs[7]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, "DIV 7/-2"};
    vecs[8]  = '{3'b010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, "DIV -7/0"};
    vecs[9]  = '{3'b001, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, "MULTU x16"};
    vecs[10] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1, "MULT min^2"};

    rst_n = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    hilo_rd = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    chk("reset busy",  {31'd0, busy},  0);
    chk("reset done",  {31'd0, done},  0);
    chk("reset stall", {31'd0, stall}, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);

    // MTLO / MTHI in IDLE
    start = 1'b1; op = 3'b101; rs_val = 32'h1234;
    tick();
    start = 1'b0;
    chk("MTLO lo", lo, 32'h1234);
    chk("MTLO busy", {31'd0, busy}, 0);
    chk("MTLO done", {31'd0, done}, 0);
    start = 1'b1; op = 3'b100; rs_val = 32'hABCD;
    tick();
    start = 1'b0;
    chk("MTHI hi", hi, 32'hABCD);
    chk("MTHI lo kept", lo, 32'h1234);

    // flush with start in the same cycle: start dropped
    start = 1'b1; op = 3'b100; rs_val = 32'h5555; flush = 1'b1;
    tick();
    op = 3'b000;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush+MTHI hi", hi, 32'hABCD);
    chk("flush+MULT busy", {31'd0, busy}, 0);

    // unused opcode
    start = 1'b1; op = 3'b111; rs_val = 32'h9999;
    tick();
    start = 1'b0;
    chk("unused op busy", {31'd0, busy}, 0);
    chk("unused op hi", hi, 32'hABCD);
    chk("unused op lo", lo, 32'h1234);

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // flush on the 10th busy cycle of a MULT
    old_hi = hi; old_lo = lo;
    start = 1'b1; op = 3'b000; rs_val = 32'd5; rt_val = 32'd6;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("flush busy before", {31'd0, busy}, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 0);
    chk("flush done", {31'd0, done}, 0);
    chk("flush hi", hi, old_hi);
    chk("flush lo", lo, old_lo);
    repeat (40) begin
      if (done !== 1'b0) chk("flush late done", {31'd0, done}, 0);
      tick();
    end
    chk("flush hi later", hi, old_hi);

    // MTHI while busy, then async reset on the 20th busy cycle
    start = 1'b1; op = 3'b001; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; op = 3'b100; rs_val = 32'hDEAD;
    #1;
    chk("MTHI busy stall", {31'd0, stall}, 1);
    tick();
    start = 1'b0;
    chk("MTHI busy hi", hi, old_hi);
    repeat (16) tick();
    chk("pre-reset busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 0);
    chk("midrst done", {31'd0, done}, 0);
    chk("midrst hi", hi, 0);
    chk("midrst lo", lo, 0);
    rst_n = 1'b1;
    tick();
    chk("postrst busy", {31'd0, busy}, 0);

    // back-to-back after reset
    run_op(vecs[0]);
    run_op(vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core, sitting beside the single-cycle ALU in the EX stage. It sequences 32-step shift-add multiplication and restoring division for MULT/MULTU/DIV/DIVU, services MTHI/MTLO, and tells the hazard logic when EX must stall because HI/LO are not yet valid or the unit is occupied.

## Interface
- No parameters; operand width fixed at 32, HI/LO 32 each.
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  EX-stage instruction is a muldiv op (qualified by op)
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others ignored
- rs_val  in  32  rs operand (multiplicand / dividend / MTHI-MTLO source)
- rt_val  in  32  rt operand (multiplier / divisor)
- hilo_rd  in  1  EX-stage instruction is MFHI/MFLO
- flush  in  1  pipeline flush; aborts any op in flight
- busy  out  1  operation in progress
- stall  out  1  combinational: busy & (start | hilo_rd)
- done  out  1  one-cycle pulse after HI/LO written by a mul/div
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE: on start with op MULT..DIVU and flush=0: latch operand magnitudes (abs for signed ops, raw for unsigned), latch result-sign flags, clear 64-bit accumulator, count=0, go RUN.
- IDLE: start with MTHI writes hi=rs_val; MTLO writes lo=rs_val; same edge, no busy, no done.
- RUN: one iteration per cycle, 5-bit count 0..31; after the 32nd iteration (count==31) go FIX.
- Multiply: shift-add, 64-bit unsigned product of magnitudes.
- Divide: restoring, 33-bit partial remainder; quotient bit set when subtract is non-negative.
- FIX: apply sign, write hi/lo, go IDLE, assert done next cycle.
  - MULT: negate 64-bit product if operand signs differ; hi=[63:32], lo=[31:0].
  - DIV: lo=quotient, negated if signs differ; hi=remainder, sign of dividend.
  - 0x80000000 / -1 (DIV): lo=0x80000000, hi=0 (falls out of magnitude algorithm).
  - Divisor zero (DIV or DIVU): full 33-cycle timing kept; lo=0xFFFFFFFF, hi=rs_val raw.
- start while busy: ignored by unit (stall holds instruction in EX; reissued when busy drops).
- hilo_rd while busy: stall; hi/lo outputs hold old values until FIX edge.
- flush: any state -> IDLE next edge, hi/lo unchanged, done not pulsed. flush and start same cycle in IDLE: start ignored, including MTHI/MTLO.
- Unused op codes with start: no effect.

## Timing
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, hi=0, lo=0, count=0; stall=0 follows.
- Edge E0 accepts start; busy=1 from after E0; RUN on edges E1..E32; FIX state after E32; FIX edge E33 writes hi/lo and clears busy.
- busy high exactly 33 cycles; done high the cycle after E33 only.
- Back-to-back: new start accepted the cycle busy is low (cycle after E33); stalled instruction sees busy=0 then and issues.
- MFHI/MFLO in cycle after E33 reads new values, no stall.
- MTHI/MTLO: latency 1 edge; value visible next cycle.
- Reset mid-operation: immediate return to reset values, no done.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=7 -> busy 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one pulse.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; hilo_rd asserted during busy -> stall=1 every busy cycle, 0 after.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT started, flush at 10th busy cycle -> busy=0 next cycle, hi/lo keep prior values, no done; MTLO 0x1234 in IDLE -> lo=0x1234 next cycle, busy stays 0.
- rst_n low at 20th busy cycle -> busy/done/hi/lo=0 immediately; start with MTHI while busy -> stall=1, hi unchanged.
